// File: rtl/sram_block_loader.sv
// ---------------------------------------------------------------------------
// sram_block_loader
//
// Purpose:
//   Sits directly downstream of the SRAM load controller. Each accepted
//   start_sram pulse reads one contiguous block of words from external SRAM
//   and streams the returned words, tagged with a 0-based local write index,
//   into the image/weight buffer. The block is either the image block or the
//   next coefficient block; the coefficient block pointer advances after
//   every coefficient load and wraps after NUM_COEF_BLK blocks. An image
//   load rewinds the coefficient pointer to block 0.
//
// Ports:
//   clk          system clock
//   n_rst        asynchronous active-low reset
//   start_sram   one-cycle request to begin a block load (honoured in IDLE only)
//   n_coef_image 1 = image load, 0 = coefficient load (sampled on accept)
//   hold         buffer back-pressure; stalls read issue, not read return
//   sram_rdata   SRAM read data, valid RD_LAT cycles after sram_re
//   sram_re      SRAM read enable
//   sram_addr    SRAM read address
//   wr_en        buffer write strobe
//   wr_data      buffer write data
//   wr_index     word offset within the block
//   busy         high while the load is issuing or draining
//   sram_done    one-cycle completion pulse
// ---------------------------------------------------------------------------
module sram_block_loader #(
    parameter int                ADDR_W       = 16,
    parameter int                DATA_W       = 16,
    parameter logic [ADDR_W-1:0] IMAGE_BASE   = 16'h0000,
    parameter int                IMAGE_WORDS  = 64,
    parameter logic [ADDR_W-1:0] COEF_BASE    = 16'h1000,
    parameter int                COEF_WORDS   = 32,
    parameter int                NUM_COEF_BLK = 4,
    parameter int                RD_LAT       = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start_sram,
    input  logic              n_coef_image,
    input  logic              hold,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_re,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] wr_index,
    output logic              busy,
    output logic              sram_done
);

    localparam int PTR_W = (NUM_COEF_BLK > 1) ? $clog2(NUM_COEF_BLK) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_reg;
    state_t            state_next;

    logic              mode_reg;        // 1 = image load in progress
    logic [PTR_W-1:0]  ptr_reg;         // coefficient block pointer
    logic [ADDR_W-1:0] base_reg;
    logic [ADDR_W-1:0] len_reg;
    logic [ADDR_W-1:0] issue_cnt_reg;
    logic [ADDR_W-1:0] ret_cnt_reg;
    logic              vld_reg [RD_LAT]; // one tag per in-flight read

    logic              start_acc;
    logic              issue_fire;
    logic              ret_fire;
    logic              last_issue;
    logic              drained;
    logic [ADDR_W-1:0] coef_base;
    logic [PTR_W-1:0]  ptr_wrapped;

    // Start is only honoured in IDLE; pulses in any other state (DONE
    // included) are dropped without touching mode, base or length.
    assign start_acc  = (state_reg == S_IDLE) && start_sram;
    assign issue_fire = (state_reg == S_ISSUE) && !hold;
    assign ret_fire   = vld_reg[RD_LAT-1];
    assign last_issue = (issue_cnt_reg == (len_reg - ADDR_W'(1)));
    // Completion is taken from the registered return count, so DONE lands
    // one cycle after the cycle following the final write.
    assign drained    = (ret_cnt_reg == len_reg);

    // Address arithmetic is modulo 2^ADDR_W by construction.
    assign coef_base   = COEF_BASE + (ADDR_W'(ptr_reg) * ADDR_W'(COEF_WORDS));
    assign ptr_wrapped = (ptr_reg == PTR_W'(NUM_COEF_BLK - 1)) ? '0
                                                              : ptr_reg + PTR_W'(1);

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start_sram)              state_next = S_ISSUE;
            S_ISSUE: if (!hold && last_issue)     state_next = S_DRAIN;
            S_DRAIN: if (drained)                 state_next = S_DONE;
            S_DONE:                               state_next = S_IDLE;
            default:                              state_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs. Everything is decoded from asynchronously reset state,
    // so all outputs drop to zero the moment n_rst falls. Write data and
    // index are gated so they read zero between writes.
    // ---------------------------------------------------------------------
    always_comb begin
        sram_re   = issue_fire;
        sram_addr = '0;
        if (state_reg == S_ISSUE) begin
            // Address stays presented (frozen) while hold stalls the issue.
            sram_addr = base_reg + issue_cnt_reg;
        end
        wr_en     = ret_fire;
        wr_data   = ret_fire ? sram_rdata  : '0;
        wr_index  = ret_fire ? ret_cnt_reg : '0;
        busy      = (state_reg == S_ISSUE) || (state_reg == S_DRAIN);
        sram_done = (state_reg == S_DONE);
    end

    // ---------------------------------------------------------------------
    // Load descriptor, counters and coefficient pointer
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mode_reg      <= 1'b0;
            ptr_reg       <= '0;
            base_reg      <= '0;
            len_reg       <= '0;
            issue_cnt_reg <= '0;
            ret_cnt_reg   <= '0;
        end else if (start_acc) begin
            mode_reg      <= n_coef_image;
            issue_cnt_reg <= '0;
            ret_cnt_reg   <= '0;
            if (n_coef_image) begin
                base_reg <= IMAGE_BASE;
                len_reg  <= ADDR_W'(IMAGE_WORDS);
                ptr_reg  <= '0;
            end else begin
                base_reg <= coef_base;
                len_reg  <= ADDR_W'(COEF_WORDS);
            end
        end else begin
            if (issue_fire) begin
                issue_cnt_reg <= issue_cnt_reg + ADDR_W'(1);
            end
            if (ret_fire) begin
                ret_cnt_reg <= ret_cnt_reg + ADDR_W'(1);
            end
            if ((state_reg == S_DONE) && !mode_reg) begin
                ptr_reg <= ptr_wrapped;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Read-valid shift register: a tag enters with each issued read and
    // leaves RD_LAT cycles later, aligned with its data on sram_rdata.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_reg[0] <= 1'b0;
        end else begin
            vld_reg[0] <= issue_fire;
        end
    end

    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_vld
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    vld_reg[gi] <= 1'b0;
                end else begin
                    vld_reg[gi] <= vld_reg[gi-1];
                end
            end
        end
    endgenerate

endmodule
